// File: rtl/debug_tx_buffer_pkg.sv
// Shared definitions for the debug transmit buffer: read-FSM encodings and drop-counter ceiling.
package debug_tx_buffer_pkg;
  localparam logic       TXB_IDLE     = 1'd0;
  localparam logic       TXB_HOLD     = 1'd1;
  localparam logic [7:0] TXB_DROP_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE = TXB_IDLE,
    ST_HOLD = TXB_HOLD
  } txb_state_e;
endpackage

// File: rtl/debug_tx_buffer_if.sv
// Byte stream between message generator, buffer and AVR transmitter.
interface debug_tx_buffer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_busy;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       new_tx_data;

  modport slave  (input  in_data, in_valid, tx_busy,
                  output in_busy, tx_data, new_tx_data);
  modport master (output in_data, in_valid, tx_busy,
                  input  in_busy, tx_data, new_tx_data);
endinterface

// File: rtl/debug_tx_buffer_sync_fifo_8.sv
// Byte-wide synchronous FIFO; storage is unreset, only pointers and fill count are.
module sync_fifo_8
  import debug_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk)
    if (push && !clr) r_mem[r_wptr] <= din;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + AW'(1);
      if (pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
endmodule

// File: rtl/debug_tx_buffer.sv
// Elastic byte buffer feeding the AVR serial transmitter, with holdoff pacing,
// upstream backpressure and dropped-byte accounting.
module debug_tx_buffer
  import debug_tx_buffer_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int HOLDOFF = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  debug_tx_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_count
);
  logic [7:0]             w_dout;
  logic [$clog2(DEPTH):0] w_level;
  logic                   w_full, w_empty, w_push, w_pop;

  txb_state_e r_state;
  logic [3:0] r_hold;
  logic [7:0] r_tx_data;
  logic       r_new_tx;
  logic       r_ovf;
  logic [7:0] r_drop;

  // Flush outranks both sides; full comes from the registered level, so a
  // same-cycle pop never rescues a write into a full buffer.
  assign w_push = bus.in_valid && !w_full && !flush;
  assign w_pop  = (r_state == ST_IDLE) && !w_empty && !bus.tx_busy && !flush;

  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.in_data),
    .dout  (w_dout),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_tx_data <= '0;
      r_new_tx  <= 1'b0;
    end else if (flush) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_new_tx <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_new_tx <= w_pop;
          if (w_pop) begin
            r_tx_data <= w_dout;
            r_hold    <= 4'(HOLDOFF);
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_new_tx <= 1'b0;
          r_hold   <= r_hold - 4'd1;
          if (r_hold == 4'd1) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (flush) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (bus.in_valid && w_full) begin
      r_ovf <= 1'b1;
      if (r_drop != TXB_DROP_MAX) r_drop <= r_drop + 8'd1;
    end
  end

  assign bus.in_busy     = w_full;
  assign bus.tx_data     = r_tx_data;
  assign bus.new_tx_data = r_new_tx;
  assign level           = w_level;
  assign overflow        = r_ovf;
  assign drop_count      = r_drop;
endmodule

// File: tb/tb_debug_tx_buffer.sv
// Scoreboard bench for debug_tx_buffer: expected bytes are queued at issue time
// and a negedge monitor pops and compares them against each new_tx_data strobe.
module tb_debug_tx_buffer;
  localparam int DEPTH   = 64;
  localparam int HOLDOFF = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [6:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  debug_tx_buffer_if bus();

  debug_tx_buffer #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         cyc = 0;
  int         prev_cyc = -1;
  logic       exact_gap = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && level == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", int'(done), 1);
  endtask

  // Monitor: every strobe must match the oldest outstanding expected byte.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.new_tx_data) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", int'(bus.tx_data), -1);
        end else begin
          exp_b = sb.pop_front();
          chk("tx_data_order", int'(bus.tx_data), int'(exp_b));
        end
        if (exact_gap && prev_cyc >= 0) chk("strobe_gap", cyc - prev_cyc, HOLDOFF + 1);
        prev_cyc = exact_gap ? cyc : -1;
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.tx_busy = 1'b0;
    step(); step();
    chk("rst_level", int'(level), 0);
    chk("rst_new_tx", int'(bus.new_tx_data), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_in_busy", int'(bus.in_busy), 0);
    rst = 1'b1;
    step();

    // Single byte latency
    bus.in_valid = 1'b1; bus.in_data = 8'h41; sb.push_back(8'h41);
    step();
    bus.in_valid = 1'b0;
    chk("t1_level_after_write", int'(level), 1);
    chk("t1_no_strobe_yet", int'(bus.new_tx_data), 0);
    step();
    chk("t1_strobe", int'(bus.new_tx_data), 1);
    chk("t1_tx_data", int'(bus.tx_data), 8'h41);
    chk("t1_level_empty", int'(level), 0);
    step();
    chk("t1_strobe_one_cycle", int'(bus.new_tx_data), 0);
    chk("t1_tx_data_held", int'(bus.tx_data), 8'h41);

    // Fill to full while stalled
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i); sb.push_back(8'(i));
      step();
    end
    bus.in_valid = 1'b0;
    chk("t2_level_full", int'(level), 64);
    chk("t2_in_busy", int'(bus.in_busy), 1);
    chk("t2_no_overflow", int'(overflow), 0);

    // Write into full buffer in the same cycle as a pop: still dropped
    bus.tx_busy = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    step();
    bus.tx_busy = 1'b1; bus.in_valid = 1'b0;
    chk("t3_pop_drop_level", int'(level), 63);
    chk("t3_pop_drop_count", int'(drop_count), 1);
    chk("t3_overflow", int'(overflow), 1);
    bus.in_valid = 1'b1; bus.in_data = 8'h40; sb.push_back(8'h40);
    step();
    chk("t3_refill_level", int'(level), 64);
    bus.in_data = 8'hBB;
    step(); step();
    bus.in_valid = 1'b0;
    chk("t3_drop3", int'(drop_count), 3);
    chk("t3_level_stays", int'(level), 64);
    bus.in_valid = 1'b1; bus.in_data = 8'hCC;
    repeat (300) step();
    bus.in_valid = 1'b0;
    chk("t3_drop_saturate", int'(drop_count), 255);
    chk("t3_level_after_drops", int'(level), 64);

    // Drain at full rate
    exact_gap = 1'b1; bus.tx_busy = 1'b0;
    wait_drain(300);
    exact_gap = 1'b0;
    step(); step(); step();

    // Sustained writes: level grows by one every two cycles
    for (int k = 0; k < 40; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h80 + k); sb.push_back(8'(8'h80 + k));
      step();
      chk("t4_level_growth", int'(level), k / 2 + 1);
    end
    bus.in_valid = 1'b0;
    wait_drain(200);
    step(); step();

    // Flush with a same-cycle write
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'hD0 + i);
      step();
    end
    chk("t5_level_10", int'(level), 10);
    chk("t5_overflow_before", int'(overflow), 1);
    flush = 1'b1; bus.in_data = 8'hEE;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("t5_flush_level", int'(level), 0);
    chk("t5_flush_overflow", int'(overflow), 0);
    chk("t5_flush_drop", int'(drop_count), 0);
    chk("t5_flush_in_busy", int'(bus.in_busy), 0);
    bus.tx_busy = 1'b0;
    repeat (10) step();
    chk("t5_still_empty", int'(level), 0);
    bus.in_valid = 1'b1; bus.in_data = 8'h55; sb.push_back(8'h55);
    step();
    bus.in_valid = 1'b0;
    wait_drain(50);
    step(); step();

    // Asynchronous reset while in HOLD
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h60 + i);
      step();
    end
    bus.in_valid = 1'b0;
    sb.push_back(8'h60);
    bus.tx_busy = 1'b0;
    @(posedge clk);
    #6;
    chk("t6_strobe_before_rst", int'(bus.new_tx_data), 1);
    chk("t6_level_before_rst", int'(level), 2);
    rst = 1'b0;
    #1;
    chk("t6_rst_new_tx", int'(bus.new_tx_data), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_tx_data", int'(bus.tx_data), 0);
    chk("t6_sb_consumed", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    bus.in_valid = 1'b1; bus.in_data = 8'h77; sb.push_back(8'h77);
    step();
    bus.in_valid = 1'b0;
    chk("t6_post_rst_level", int'(level), 1);
    chk("t6_post_rst_no_strobe", int'(bus.new_tx_data), 0);
    step();
    chk("t6_post_rst_strobe", int'(bus.new_tx_data), 1);
    chk("t6_post_rst_data", int'(bus.tx_data), 8'h77);
    wait_drain(20);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/debug_tx_buffer.md
Name: debug_tx_buffer

Overview:
- Elastic byte buffer between the debugging message generator and the AVR USB serial transmit interface.
- Accepts bursts of message bytes from the generator, stores up to DEPTH bytes, and drains them to the AVR one byte at a time, honouring tx_busy.
- Applies backpressure upstream and counts dropped bytes, so a full 64-byte debug line is never torn by AVR stalls.

Parameters:
- DEPTH, 64, FIFO capacity in bytes; power of two, minimum 4.
- HOLDOFF, 1, cycles after each new_tx_data pulse during which tx_busy is ignored and no new byte is issued; range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of buffer contents and status.
- in_data  input  8  byte from the message generator.
- in_valid  input  1  in_data valid this cycle; single-cycle write strobe.
- in_busy  output  1  backpressure to the generator; equals full.
- tx_busy  input  1  AVR transmitter busy.
- tx_data  output  8  byte to the AVR; registered.
- new_tx_data  output  1  one-cycle strobe; tx_data is valid this cycle.
- level  output  $clog2(DEPTH)+1  current fill count; registered.
- overflow  output  1  sticky flag: at least one byte was dropped.
- drop_count  output  8  count of dropped bytes; saturates at 255.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, level, overflow, drop_count, tx_data, and new_tx_data all go to 0.
  - The read FSM goes to IDLE.
  - All outputs are inactive until the first clk edge after rst returns high.
- Status signals:
  - full = (level == DEPTH).
  - empty = (level == 0).
  - Both are derived from the registered level.
  - in_busy = full.
- Write:
  - On a clk edge with in_valid=1 and full=0, in_data is stored at the write pointer.
  - The write pointer increments modulo DEPTH and wraps.
- Drop:
  - in_valid=1 with full=1 discards the byte.
  - overflow is set to 1.
  - drop_count increments and saturates at 255.
  - This applies even if a pop occurs in the same cycle; full is evaluated from the registered level.
- Read FSM, two states:
  - IDLE: if empty=0 and tx_busy=0, pop the head byte into tx_data, assert new_tx_data for exactly one cycle, load the holdoff counter with HOLDOFF, and go to HOLD.
  - HOLD: new_tx_data=0 and tx_busy is ignored. The counter decrements each cycle; go to IDLE when it reaches 0 (i.e. after HOLDOFF cycles).
- Latency:
  - A byte written at edge E into an empty buffer, with tx_busy=0, produces new_tx_data visible after edge E+1.
  - Maximum issue rate is one byte per HOLDOFF+1 cycles.
- Simultaneous write and pop:
  - Both occur and level is unchanged.
  - level is updated by +1 on write only, -1 on pop only, and 0 on both or neither.
- tx_data holds its last value between strobes.
- Flush:
  - Clears pointers, level, overflow, and drop_count.
  - Forces the FSM to IDLE and new_tx_data to 0 on the next edge.
  - flush has priority over a same-cycle write or pop; the write is discarded and not counted as dropped.
- Ordering: bytes leave in exactly the order accepted; no duplication.
- Storage: a plain register array with no reset on its contents; only pointers are reset.

Decomposition:
- Shared header, included like the other Util headers:
  - read-FSM state localparams: TXB_IDLE=1'd0, TXB_HOLD=1'd1.
  - TXB_DROP_MAX=8'hFF.
- One natural sub-module, sync_fifo_8:
  - Parameterised DEPTH, with push/pop/data/level/full/empty.
  - Owns the storage array and pointer wrap.
- debug_tx_buffer owns the read FSM, holdoff counter, drop accounting, and flush priority.

Test Plan:
- Reset release, tx_busy=0, write 0x41 once → new_tx_data pulses one cycle, one edge after the write, with tx_data=0x41; level returns to 0.
- tx_busy=1, write 64 bytes 0x00..0x3F → level=64, in_busy=1. Release tx_busy → 64 strobes in order 0x00..0x3F, spaced HOLDOFF+1=2 cycles apart.
- Full buffer, write 3 more bytes → overflow=1, drop_count=3, level stays 64. Then 300 more writes → drop_count=255.
- Sustained in_valid every cycle with tx_busy=0 → level grows by 1 every 2 cycles; simultaneous push and pop leave level unchanged on those cycles; output order is preserved across pointer wrap.
- Assert flush in the same cycle as a write, with 10 bytes buffered → next cycle level=0, overflow=0, drop_count=0; no new_tx_data for the flushed bytes; the flush-cycle byte is not stored.
- Drop rst low asynchronously while in HOLD, mid-message → new_tx_data=0, level=0, and FSM in IDLE immediately, without waiting for a clk edge.
